// File: rtl/motor_cmd_pkg.sv
// rtl/motor_cmd_pkg.sv - shared ramp state type, default sizes and packed-bus helper
// Used by motor_cmd_arbiter and motor_ramp (import motor_cmd_pkg::*).
// Contents: ramp_state_t, DEF_SPEED_W, DEF_RAMP_DIV, src_speed_at().
package motor_cmd_pkg;

  typedef enum logic [1:0] {HOLD, UP, DOWN, REVERSE} ramp_state_t;

  localparam int DEF_SPEED_W  = 4;
  localparam int DEF_RAMP_DIV = 1000000;

  // Widest packed source bus and speed field the helper can extract from.
  localparam int MAX_BUS_W   = 256;
  localparam int MAX_SPEED_W = 32;

  // Returns the speed field of source idx from a packed bus of width-bit fields.
  function automatic logic [MAX_SPEED_W-1:0] src_speed_at(
    input logic [MAX_BUS_W-1:0] bus,
    input int                   idx,
    input int                   width
  );
    logic [MAX_BUS_W-1:0]   shifted;
    logic [MAX_SPEED_W-1:0] field;
    shifted = bus >> (idx * width);
    field   = '0;
    for (int b = 0; b < MAX_SPEED_W; b++) begin
      if (b < width) field[b] = shifted[b];
    end
    return field;
  endfunction

endpackage

// File: rtl/motor_ramp.sv
// rtl/motor_ramp.sv - soft-start ramp with safe reversal for the applied speed/turn
// Ports:
//   clk100, reset          clock and synchronous active-high reset
//   tgt_speed, tgt_turn    target the output ramps towards
//   speed, turn            applied (ramped) speed and direction, registered
//   busy                   high while speed/turn differ from the target
//   settled                one-cycle pulse in the first cycle busy is low again
module motor_ramp
  import motor_cmd_pkg::*;
#(
  parameter int SPEED_W  = DEF_SPEED_W,
  parameter int RAMP_DIV = DEF_RAMP_DIV
) (
  input  logic               clk100,
  input  logic               reset,
  input  logic [SPEED_W-1:0] tgt_speed,
  input  logic               tgt_turn,
  output logic [SPEED_W-1:0] speed,
  output logic               turn,
  output logic               busy,
  output logic               settled
);

  localparam int               CNT_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_DIV - 1);

  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  ramp_state_t      state;
  ramp_state_t      state_next;

  // Free-running divider: retargeting never restarts it.
  assign tick = (tick_cnt == CNT_LAST);

  // Direction must match before any acceleration: slow to zero, flip, then climb.
  always_comb begin
    state_next = HOLD;
    if (turn != tgt_turn)        state_next = (speed != '0) ? DOWN : REVERSE;
    else if (speed < tgt_speed)  state_next = UP;
    else if (speed > tgt_speed)  state_next = DOWN;
  end

  always_ff @(posedge clk100) begin
    if (reset) begin
      tick_cnt <= '0;
      state    <= HOLD;
      speed    <= '0;
      turn     <= 1'b0;
      busy     <= 1'b0;
      settled  <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      state    <= state_next;
      busy     <= (state_next != HOLD);
      settled  <= (state != HOLD) && (state_next == HOLD);
      if (tick) begin
        case (state_next)
          UP:      if (speed != '1) speed <= speed + 1'b1;
          DOWN:    if (speed != '0) speed <= speed - 1'b1;
          REVERSE: turn <= tgt_turn;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/motor_cmd_arbiter.sv
// rtl/motor_cmd_arbiter.sv - N-source motor command selector feeding a soft-start ramp
// Optional feature: define MOTOR_CMD_WDOG_EN to add a command watchdog (WDOG_CYCLES, wdog_trip).
// Ports:
//   clk100, reset                   clock and synchronous active-high reset
//   src_speed/src_turn/src_done     per-source command; rising src_done = new command
//   mode_manual, sel                manual select (sel >= N_SRC picks source 0) or auto
//   speed, turn                     ramped outputs to the driver
//   active_src                      source currently providing the target
//   busy, settled                   ramp in progress / one-cycle end-of-ramp pulse
//   new_cmd                         one-cycle pulse on an accepted command edge
//   wdog_trip                       (watchdog build only) target forced to zero
module motor_cmd_arbiter
  import motor_cmd_pkg::*;
#(
  parameter int N_SRC    = 2,
  parameter int SPEED_W  = DEF_SPEED_W,
  parameter int RAMP_DIV = DEF_RAMP_DIV,
`ifdef MOTOR_CMD_WDOG_EN
  parameter int WDOG_CYCLES = 200000000,
`endif
  localparam int SEL_W   = $clog2(N_SRC)
) (
  input  logic                     clk100,
  input  logic                     reset,
  input  logic [N_SRC*SPEED_W-1:0] src_speed,
  input  logic [N_SRC-1:0]         src_turn,
  input  logic [N_SRC-1:0]         src_done,
  input  logic                     mode_manual,
  input  logic [SEL_W-1:0]         sel,
  output logic [SPEED_W-1:0]       speed,
  output logic                     turn,
  output logic [SEL_W-1:0]         active_src,
  output logic                     busy,
  output logic                     settled,
`ifdef MOTOR_CMD_WDOG_EN
  output logic                     wdog_trip,
`endif
  output logic                     new_cmd
);

  logic [N_SRC-1:0]   done_q;
  logic [N_SRC-1:0]   rise;
  logic               rise_any;
  logic [SEL_W-1:0]   rise_idx;
  logic [SEL_W-1:0]   sel_eff;
  logic [SEL_W-1:0]   pick;
  logic               cmd_accept;
  logic [SPEED_W-1:0] tgt_speed;
  logic               tgt_turn;
  logic [SPEED_W-1:0] ramp_tgt_speed;

  assign rise    = src_done & ~done_q;
  assign sel_eff = (int'(sel) < N_SRC) ? sel : '0;

  // Lowest-index rising source wins when several arrive together.
  always_comb begin
    rise_any = |rise;
    rise_idx = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (rise[i]) rise_idx = SEL_W'(i);
    end
  end

  assign pick       = mode_manual ? sel_eff : rise_idx;
  assign cmd_accept = mode_manual ? rise[sel_eff] : rise_any;

  // Manual mode tracks the selected source every cycle; auto mode only
  // reloads on a command edge, so a manual->auto switch keeps the last target.
  always_ff @(posedge clk100) begin
    if (reset) begin
      done_q     <= '0;
      new_cmd    <= 1'b0;
      active_src <= '0;
      tgt_speed  <= '0;
      tgt_turn   <= 1'b0;
    end else begin
      done_q  <= src_done;
      new_cmd <= cmd_accept;
      if (mode_manual || rise_any) begin
        active_src <= pick;
        tgt_speed  <= SPEED_W'(src_speed_at(MAX_BUS_W'(src_speed), int'(pick), SPEED_W));
        tgt_turn   <= src_turn[pick];
      end
    end
  end

`ifdef MOTOR_CMD_WDOG_EN
  logic [31:0] wdog_cnt;

  // Saturates at WDOG_CYCLES; only an accepted command re-arms it.
  always_ff @(posedge clk100) begin
    if (reset || cmd_accept) begin
      wdog_cnt  <= '0;
      wdog_trip <= 1'b0;
    end else if (wdog_cnt == 32'(WDOG_CYCLES)) begin
      wdog_trip <= 1'b1;
    end else begin
      wdog_cnt <= wdog_cnt + 1'b1;
    end
  end

  assign ramp_tgt_speed = wdog_trip ? '0 : tgt_speed;
`else
  assign ramp_tgt_speed = tgt_speed;
`endif

  motor_ramp #(
    .SPEED_W  (SPEED_W),
    .RAMP_DIV (RAMP_DIV)
  ) u_ramp (
    .clk100    (clk100),
    .reset     (reset),
    .tgt_speed (ramp_tgt_speed),
    .tgt_turn  (tgt_turn),
    .speed     (speed),
    .turn      (turn),
    .busy      (busy),
    .settled   (settled)
  );

endmodule

// File: tb/tb_motor_cmd_arbiter.sv
// tb/tb_motor_cmd_arbiter.sv - self-checking bench for motor_cmd_arbiter
module tb_motor_cmd_arbiter;

  localparam int N_SRC    = 3;
  localparam int SPEED_W  = 4;
  localparam int RAMP_DIV = 4;
  localparam int SEL_W    = 2;

  logic                     clk100 = 1'b0;
  logic                     reset  = 1'b1;
  logic [N_SRC*SPEED_W-1:0] src_speed = '0;
  logic [N_SRC-1:0]         src_turn  = '0;
  logic [N_SRC-1:0]         src_done  = '0;
  logic                     mode_manual = 1'b1;
  logic [SEL_W-1:0]         sel = '0;
  logic [SPEED_W-1:0]       speed;
  logic                     turn;
  logic [SEL_W-1:0]         active_src;
  logic                     busy;
  logic                     settled;
  logic                     new_cmd;
`ifdef MOTOR_CMD_WDOG_EN
  logic                     wdog_trip;
`endif

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  always #5 clk100 = ~clk100;

  motor_cmd_arbiter #(
    .N_SRC    (N_SRC),
    .SPEED_W  (SPEED_W),
    .RAMP_DIV (RAMP_DIV)
  ) dut (
    .clk100      (clk100),
    .reset       (reset),
    .src_speed   (src_speed),
    .src_turn    (src_turn),
    .src_done    (src_done),
    .mode_manual (mode_manual),
    .sel         (sel),
    .speed       (speed),
    .turn        (turn),
    .active_src  (active_src),
    .busy        (busy),
    .settled     (settled),
`ifdef MOTOR_CMD_WDOG_EN
    .wdog_trip   (wdog_trip),
`endif
    .new_cmd     (new_cmd)
  );

  // Reference model: one step per clock, written from the behavioural rules.
  int               m_speed, m_active, m_tgt_speed, m_phase;
  bit               m_turn, m_tgt_turn, m_busy, m_settled, m_new;
  logic [N_SRC-1:0] m_prev_done;

  always @(posedge clk100) begin : ref_model
    logic [N_SRC-1:0] r;
    bit tick, moving;
    int idx;
    if (reset) begin
      m_speed = 0; m_turn = 0; m_active = 0; m_tgt_speed = 0; m_tgt_turn = 0;
      m_phase = 0; m_busy = 0; m_settled = 0; m_new = 0; m_prev_done = '0;
    end else begin
      r = src_done & ~m_prev_done;
      tick = (m_phase == RAMP_DIV - 1);
      m_phase = (m_phase + 1) % RAMP_DIV;
      moving = 1;
      if (m_turn != m_tgt_turn) begin
        if (m_speed > 0) begin
          if (tick) m_speed = m_speed - 1;
        end else if (tick) begin
          m_turn = m_tgt_turn;
        end
      end else if (m_speed != m_tgt_speed) begin
        if (tick) m_speed = m_speed + ((m_speed < m_tgt_speed) ? 1 : -1);
      end else begin
        moving = 0;
      end
      m_settled = m_busy && !moving;
      m_busy = moving;
      if (mode_manual) begin
        idx = (int'(sel) < N_SRC) ? int'(sel) : 0;
        m_active = idx;
        m_tgt_speed = int'(src_speed[idx*SPEED_W +: SPEED_W]);
        m_tgt_turn = src_turn[idx];
        m_new = r[idx];
      end else begin
        idx = -1;
        for (int i = N_SRC - 1; i >= 0; i--) if (r[i]) idx = i;
        m_new = (idx >= 0);
        if (idx >= 0) begin
          m_active = idx;
          m_tgt_speed = int'(src_speed[idx*SPEED_W +: SPEED_W]);
          m_tgt_turn = src_turn[idx];
        end
      end
      m_prev_done = src_done;
    end
  end

  always @(negedge clk100) begin : monitor
    logic [SPEED_W+SEL_W+3:0] got, exp;
    if (mon_en) begin
      got = {speed, turn, active_src, busy, settled, new_cmd};
      exp = {SPEED_W'(m_speed), m_turn, SEL_W'(m_active), m_busy, m_settled, m_new};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL model t=%0t speed %0d/%0d turn %0d/%0d act %0d/%0d busy %0d/%0d settled %0d/%0d new_cmd %0d/%0d",
                 $time, speed, m_speed, turn, m_turn, active_src, m_active, busy, m_busy,
                 settled, m_settled, new_cmd, m_new);
      end
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic set_src(input int i, input int spd, input bit trn);
    src_speed[i*SPEED_W +: SPEED_W] = SPEED_W'(spd);
    src_turn[i] = trn;
  endtask

  task automatic wait_speed(input int val, input int limit, input string name);
    int n = 0;
    while (int'(speed) != val && n < limit) begin
      @(negedge clk100);
      n++;
    end
    check(name, int'(speed), val);
  endtask

  typedef struct {
    bit         manual;
    int         sel;
    int         spd0, spd1, spd2;
    logic [2:0] trn;
    logic [2:0] done;
    int         exp_active;
    int         exp_speed;
    bit         exp_turn;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int prev_speed, prev_turn, nchg, last_cyc, settled_cnt, bad, flips, pulses;
    int vals[$];
    int gaps[$];

    vecs[0] = '{1, 1, 0, 3, 0,  3'b000, 3'b000, 1, 3, 0};
    vecs[1] = '{1, 2, 0, 3, 9,  3'b100, 3'b000, 2, 9, 1};
    vecs[2] = '{1, 3, 5, 3, 9,  3'b100, 3'b000, 0, 5, 0};
    vecs[3] = '{0, 0, 5, 7, 2,  3'b110, 3'b110, 1, 7, 1};
    vecs[4] = '{0, 0, 15, 7, 2, 3'b111, 3'b001, 0, 15, 1};
    vecs[5] = '{0, 0, 1, 1, 1,  3'b000, 3'b000, 0, 15, 1};
    vecs[6] = '{1, 0, 0, 1, 1,  3'b000, 3'b000, 0, 0, 0};
    vecs[7] = '{0, 0, 0, 1, 15, 3'b000, 3'b100, 2, 15, 0};

    mon_en = 1'b1;
    repeat (2) @(negedge clk100);
    check("rst_speed", int'(speed), 0);
    check("rst_turn", int'(turn), 0);
    check("rst_active", int'(active_src), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_settled", int'(settled), 0);
    check("rst_new_cmd", int'(new_cmd), 0);
    reset = 1'b0;

    // Table: apply a command, let the ramp finish, check the resting outputs.
    for (int k = 0; k < 8; k++) begin
      src_done = '0;
      repeat (2) @(negedge clk100);
      mode_manual = vecs[k].manual;
      sel = SEL_W'(vecs[k].sel);
      set_src(0, vecs[k].spd0, vecs[k].trn[0]);
      set_src(1, vecs[k].spd1, vecs[k].trn[1]);
      set_src(2, vecs[k].spd2, vecs[k].trn[2]);
      src_done = vecs[k].done;
      repeat (140) @(negedge clk100);
      check($sformatf("vec%0d_active", k), int'(active_src), vecs[k].exp_active);
      check($sformatf("vec%0d_speed", k), int'(speed), vecs[k].exp_speed);
      check($sformatf("vec%0d_turn", k), int'(turn), int'(vecs[k].exp_turn));
      check($sformatf("vec%0d_busy", k), int'(busy), 0);
    end

    // Manual ramp-up 0 -> 3 from reset.
    src_done = '0; reset = 1'b1;
    @(negedge clk100);
    reset = 1'b0;
    src_speed = '0; src_turn = '0;
    mode_manual = 1'b1; sel = 2'd1;
    set_src(1, 3, 0);
    prev_speed = 0; nchg = 0; last_cyc = 0; settled_cnt = 0; bad = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk100);
      if (settled) settled_cnt++;
      if (int'(speed) != prev_speed) begin
        vals.push_back(int'(speed));
        if (nchg > 0) gaps.push_back(c - last_cyc);
        nchg++; last_cyc = c; prev_speed = int'(speed);
      end
      if (nchg > 0 && int'(speed) != 3 && !busy) bad++;
    end
    check("up_nchg", nchg, 3);
    if (vals.size() == 3) begin
      check("up_step1", vals[0], 1);
      check("up_step2", vals[1], 2);
      check("up_step3", vals[2], 3);
      check("up_gap1", gaps[0], 4);
      check("up_gap2", gaps[1], 4);
    end
    check("up_settled_pulses", settled_cnt, 1);
    check("up_busy_gaps", bad, 0);

    // Reversal from speed 2 forward to speed 2 reverse.
    set_src(1, 2, 0);
    repeat (30) @(negedge clk100);
    check("rev_start", int'(speed), 2);
    src_turn[1] = 1'b1;
    vals.delete();
    prev_speed = int'(speed); prev_turn = int'(turn); flips = 0; bad = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk100);
      if (int'(turn) != prev_turn) begin
        flips++;
        if (prev_speed != 0 || int'(speed) != 0) bad++;
      end
      if (int'(speed) != prev_speed) vals.push_back(int'(speed));
      prev_speed = int'(speed); prev_turn = int'(turn);
    end
    check("rev_flips", flips, 1);
    check("rev_flip_at_zero", bad, 0);
    check("rev_nchg", vals.size(), 4);
    if (vals.size() == 4) begin
      check("rev_seq0", vals[0], 1);
      check("rev_seq1", vals[1], 0);
      check("rev_seq2", vals[2], 1);
      check("rev_seq3", vals[3], 2);
    end
    check("rev_turn", int'(turn), 1);

    // Auto: simultaneous edges, lowest index wins; later edge switches source.
    src_done = '0;
    set_src(0, 7, 0); set_src(1, 9, 0);
    mode_manual = 1'b0;
    repeat (2) @(negedge clk100);
    src_done = 3'b011;
    @(negedge clk100);
    check("auto_active0", int'(active_src), 0);
    check("auto_new_cmd", int'(new_cmd), 1);
    @(negedge clk100);
    check("auto_new_cmd_end", int'(new_cmd), 0);
    wait_speed(7, 100, "auto_speed7");
    src_done = '0;
    repeat (2) @(negedge clk100);
    src_done = 3'b010;
    @(negedge clk100);
    check("auto_active1", int'(active_src), 1);
    wait_speed(9, 40, "auto_speed9");

    // Out-of-range select and a long-held done level.
    src_done = '0;
    mode_manual = 1'b1; sel = 2'd3;
    repeat (2) @(negedge clk100);
    check("sel_oor_active", int'(active_src), 0);
    src_done = 3'b001;
    pulses = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk100);
      if (new_cmd) pulses++;
    end
    check("held_done_pulses", pulses, 1);

    // Reset in the middle of a ramp.
    reset = 1'b1;
    @(negedge clk100);
    reset = 1'b0; sel = 2'd0;
    set_src(0, 15, 1);
    wait_speed(5, 80, "mid_ramp_reach5");
    reset = 1'b1;
    @(negedge clk100);
    check("midrst_speed", int'(speed), 0);
    check("midrst_turn", int'(turn), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_active", int'(active_src), 0);
    reset = 1'b0;

    // Randomised traffic checked cycle by cycle against the model.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk100);
      reset = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 19) == 0) mode_manual = $urandom_range(0, 1);
      if ($urandom_range(0, 9) == 0) sel = SEL_W'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) src_speed = (N_SRC*SPEED_W)'($urandom);
      if ($urandom_range(0, 15) == 0) src_turn = N_SRC'($urandom);
      if ($urandom_range(0, 5) == 0) src_done[$urandom_range(0, N_SRC - 1)] ^= 1'b1;
    end
    reset = 1'b0;
    repeat (2) @(negedge clk100);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
